// File: rtl/if_id_stage_register.sv
// IF/ID pipeline boundary: latches fetch results for decode, with stall, flush-to-bubble and valid tracking.
// Optional IF_ID_PERF_COUNT_EN adds stall_cycles / flush_count performance counters.
module if_id_stage_register #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        handle_exception,
    input  logic        eret_flush,
    input  logic [31:0] IF_PC,
    input  logic [31:0] IF_PC4,
    input  logic [31:0] IF_Inst,
    input  logic        IF_exception,
    input  logic [31:0] IF_EPC,
    input  logic [4:0]  IF_ExcCode,
    input  logic        IF_BD,
    input  logic        ID_is_jump,
    output logic [31:0] ID_PC,
    output logic [31:0] ID_PC4,
    output logic [31:0] ID_Inst,
    output logic        ID_valid,
    output logic        ID_exception,
    output logic [31:0] ID_EPC,
    output logic [4:0]  ID_ExcCode,
    output logic        ID_BD,
    output logic        delay_slot,
    output logic [31:0] last_PC
`ifdef IF_ID_PERF_COUNT_EN
    ,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
`endif
);

    logic flush;

    assign flush = handle_exception | eret_flush;

    // Priority: reset > flush > stall > load; reset and flush both insert a bubble.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            ID_PC        <= RESET_PC;
            ID_PC4       <= 32'(RESET_PC + 32'd4);
            ID_Inst      <= NOP_INST;
            ID_valid     <= 1'b0;
            ID_exception <= 1'b0;
            ID_EPC       <= 32'd0;
            ID_ExcCode   <= 5'd0;
            ID_BD        <= 1'b0;
        end else if (!stall) begin
            ID_PC        <= IF_PC;
            ID_PC4       <= IF_PC4;
            // A faulting fetch never forwards its (possibly garbage) word to decode.
            ID_Inst      <= IF_exception ? NOP_INST : IF_Inst;
            ID_valid     <= 1'b1;
            ID_exception <= IF_exception;
            ID_EPC       <= IF_EPC;
            ID_ExcCode   <= IF_ExcCode;
            ID_BD        <= IF_BD;
        end
    end

    // Context returned to fetch; derived only from registered ID state.
    assign delay_slot = ID_valid & ID_is_jump;
    assign last_PC    = ID_PC;

`ifdef IF_ID_PERF_COUNT_EN
    // Counters survive flushes; only reset clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= 32'd0;
            flush_count  <= 32'd0;
        end else begin
            if (flush) begin
                flush_count <= flush_count + 32'd1;
            end else if (stall) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_id_stage_register.sv
// Scoreboard bench for if_id_stage_register: directed test-plan sequence followed by random traffic.
// Define IF_ID_PERF_COUNT_EN to also check the performance counters.
module tb_if_id_stage_register;

    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        reset, stall, handle_exception, eret_flush;
    logic [31:0] IF_PC, IF_PC4, IF_Inst, IF_EPC;
    logic        IF_exception, IF_BD, ID_is_jump;
    logic [4:0]  IF_ExcCode;
    logic [31:0] ID_PC, ID_PC4, ID_Inst, ID_EPC, last_PC;
    logic        ID_valid, ID_exception, ID_BD, delay_slot;
    logic [4:0]  ID_ExcCode;
`ifdef IF_ID_PERF_COUNT_EN
    logic [31:0] stall_cycles, flush_count;
`endif

    always #5 clk = ~clk;

    if_id_stage_register dut (
        .clk(clk), .reset(reset), .stall(stall),
        .handle_exception(handle_exception), .eret_flush(eret_flush),
        .IF_PC(IF_PC), .IF_PC4(IF_PC4), .IF_Inst(IF_Inst),
        .IF_exception(IF_exception), .IF_EPC(IF_EPC), .IF_ExcCode(IF_ExcCode),
        .IF_BD(IF_BD), .ID_is_jump(ID_is_jump),
        .ID_PC(ID_PC), .ID_PC4(ID_PC4), .ID_Inst(ID_Inst), .ID_valid(ID_valid),
        .ID_exception(ID_exception), .ID_EPC(ID_EPC), .ID_ExcCode(ID_ExcCode),
        .ID_BD(ID_BD), .delay_slot(delay_slot), .last_PC(last_PC)
`ifdef IF_ID_PERF_COUNT_EN
        , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
    );

    typedef struct {
        logic [31:0] pc, pc4, inst, epc;
        logic        valid, exc, bd;
        logic [4:0]  code;
        logic        ds;
        logic [31:0] lpc;
        logic [31:0] sc, fc;
    } exp_t;

    exp_t   q[$];
    exp_t   m;          // architectural contents of the ID slot as the spec rules dictate
    int     n_cmp = 0;
    int     n_err = 0;
    int     cyc = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endfunction

    function automatic exp_t bubble(exp_t s);
        exp_t b = s;
        b.pc = RST_PC; b.pc4 = RST_PC + 32'd4; b.inst = 32'd0; b.epc = 32'd0;
        b.valid = 1'b0; b.exc = 1'b0; b.bd = 1'b0; b.code = 5'd0;
        return b;
    endfunction

    // Apply one cycle of inputs, predict the ID contents after the next edge, then wait.
    task automatic drive(input logic rst, input logic stl, input logic he, input logic er,
                         input logic [31:0] pc, input logic [31:0] inst, input logic exc,
                         input logic [31:0] epc, input logic [4:0] code, input logic bd,
                         input logic jmp);
        exp_t e;
        reset = rst; stall = stl; handle_exception = he; eret_flush = er;
        IF_PC = pc; IF_PC4 = pc + 32'd4; IF_Inst = inst; IF_exception = exc;
        IF_EPC = epc; IF_ExcCode = code; IF_BD = bd; ID_is_jump = jmp;
        if (rst) begin
            m = bubble(m); m.sc = 32'd0; m.fc = 32'd0;
        end else if (he || er) begin
            m = bubble(m); m.fc = m.fc + 32'd1;
        end else if (stl) begin
            m.sc = m.sc + 32'd1;
        end else begin
            m.pc = pc; m.pc4 = pc + 32'd4; m.inst = exc ? 32'd0 : inst;
            m.valid = 1'b1; m.exc = exc; m.epc = epc; m.code = code; m.bd = bd;
        end
        e = m;
        e.ds  = m.valid & jmp;
        e.lpc = m.pc;
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic load(input logic [31:0] pc, input logic [31:0] inst, input logic jmp);
        drive(1'b0, 1'b0, 1'b0, 1'b0, pc, inst, 1'b0, 32'd0, 5'd0, 1'b0, jmp);
    endtask

    // Monitor: the ID slot is presented every cycle; compare it against the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("ID_PC", ID_PC, e.pc);
                chk("ID_PC4", ID_PC4, e.pc4);
                chk("ID_Inst", ID_Inst, e.inst);
                chk("ID_valid", 32'(ID_valid), 32'(e.valid));
                chk("ID_exception", 32'(ID_exception), 32'(e.exc));
                chk("ID_EPC", ID_EPC, e.epc);
                chk("ID_ExcCode", 32'(ID_ExcCode), 32'(e.code));
                chk("ID_BD", 32'(ID_BD), 32'(e.bd));
                chk("delay_slot", 32'(delay_slot), 32'(e.ds));
                chk("last_PC", last_PC, e.lpc);
`ifdef IF_ID_PERF_COUNT_EN
                chk("stall_cycles", stall_cycles, e.sc);
                chk("flush_count", flush_count, e.fc);
`endif
            end
        end
    end

    initial begin
        logic        r_rst, r_stl, r_he, r_er, r_exc;
        logic [31:0] r_pc;
        m = bubble('{default: '0});

        // Reset held two cycles, then first instruction.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h3000, 32'h1234_5678, 1'b0, 32'd0, 5'd0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h3000, 32'h1234_5678, 1'b0, 32'd0, 5'd0, 1'b0, 1'b1);
        load(32'h3000, 32'h3C01_0001, 1'b0);

        // Three-cycle stall while fetch moves on; then release.
        load(32'h3004, 32'h2001_0002, 1'b0);
        repeat (3) drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h3008, 32'h2002_0003, 1'b0, 32'd0, 5'd0, 1'b0, 1'b0);
        load(32'h3008, 32'h2002_0003, 1'b0);

        // Faulting fetch, then flush coincident with stall.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h3001_0001, 32'hFFFF_FFFF, 1'b1, 32'h3001_0000, 5'd4, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h300C, 32'h0000_0001, 1'b0, 32'd0, 5'd0, 1'b0, 1'b0);

        // Branch in ID exposes delay-slot context; a bubble must hide it; both flush sources together.
        load(32'h3010, 32'h1022_0004, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h3014, 32'h0000_0002, 1'b0, 32'd0, 5'd0, 1'b1, 1'b1);
        load(32'h3018, 32'h0000_0003, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h301C, 32'h0000_0004, 1'b0, 32'd0, 5'd0, 1'b0, 1'b1);

        // Reset arriving in the middle of a stall.
        load(32'h3020, 32'h0000_0005, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h3024, 32'h0000_0006, 1'b0, 32'd0, 5'd0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h3024, 32'h0000_0006, 1'b0, 32'd0, 5'd0, 1'b0, 1'b0);

        // Random traffic.
        for (int i = 0; i < 2000; i++) begin
            r_rst = ($urandom_range(0, 63) == 0);
            r_stl = ($urandom_range(0, 3) == 0);
            r_he  = ($urandom_range(0, 11) == 0);
            r_er  = ($urandom_range(0, 15) == 0);
            r_exc = ($urandom_range(0, 7) == 0);
            r_pc  = $urandom() & 32'hFFFF_FFFC;
            if (r_exc) r_pc = r_pc | 32'(($urandom_range(1, 3)));
            drive(r_rst, r_stl, r_he, r_er, r_pc, $urandom(), r_exc,
                  r_pc & 32'hFFFF_FFFC, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/if_id_stage_register.md
Name: if_id_stage_register

Overview:
- Pipeline boundary between the instruction-fetch stage and the decode stage.
- Captures the fetched PC, PC+4, instruction word, and the fetch-side exception record (flag, EPC, ExcCode, BD) for decode.
- Supports stall (hold), flush (bubble insertion on exception entry or ERET), and a valid bit that marks bubbles.
- Returns delay-slot context (delay_slot, last_PC) to fetch so fetch can compute BD/EPC for the next instruction.

Parameters:
- RESET_PC, 32'h0000_3000, PC value loaded into ID_PC on reset and on bubble insertion.
- NOP_INST, 32'h0000_0000, instruction word presented for bubbles and for faulting fetches.

Ports:
- clk  input  1  pipeline clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hazard-unit stall; hold all ID registers.
- handle_exception  input  1  exception/interrupt taken this cycle; flush ID.
- eret_flush  input  1  ERET committing; flush ID.
- IF_PC  input  32  PC of the fetched instruction.
- IF_PC4  input  32  IF_PC+4.
- IF_Inst  input  32  fetched instruction word.
- IF_exception  input  1  fetch raised AdEL.
- IF_EPC  input  32  fetch-computed EPC (word aligned).
- IF_ExcCode  input  5  fetch exception code.
- IF_BD  input  1  fetched instruction is in a delay slot.
- ID_is_jump  input  1  decoder: the instruction in ID is a branch or jump.
- ID_PC  output  32  latched PC.
- ID_PC4  output  32  latched PC+4.
- ID_Inst  output  32  latched instruction (NOP_INST if bubble or faulting).
- ID_valid  output  1  1 = real instruction, 0 = bubble.
- ID_exception  output  1  latched exception flag.
- ID_EPC  output  32  latched EPC.
- ID_ExcCode  output  5  latched exception code.
- ID_BD  output  1  latched BD.
- delay_slot  output  1  to fetch: the next fetched instruction is a delay slot.
- last_PC  output  32  to fetch: PC of the instruction currently in ID.

Behaviour:
- Update priority at each rising clk edge: reset > (handle_exception | eret_flush) > stall > load.
- Reset or flush produces a bubble:
  - ID_PC = RESET_PC, ID_PC4 = RESET_PC+4, ID_Inst = NOP_INST.
  - ID_valid = 0, ID_exception = 0, ID_EPC = 0, ID_ExcCode = 0, ID_BD = 0.
  - Counters are not cleared by flush.
- Stall (no flush): every register holds. Stall asserted for N cycles holds the same contents for N cycles.
- Load: every ID_* register takes the corresponding IF_* value; ID_valid = 1. Latency is exactly one cycle.
- Faulting fetch (IF_exception=1 on load):
  - ID_Inst = NOP_INST, so decode never sees garbage from an unaligned or out-of-range address.
  - ID_exception, ID_EPC, ID_ExcCode, ID_BD are latched from IF; ID_valid = 1.
- Flush coincident with stall: flush wins; a bubble is loaded.
- handle_exception and eret_flush both high: a single bubble, the same as either alone.
- delay_slot = ID_valid & ID_is_jump (combinational).
- last_PC = ID_PC (combinational).
- While stalled, ID is unchanged, so delay_slot and last_PC stay stable for the held IF instruction.
- A bubble never asserts delay_slot, even if ID_is_jump is driven high.
- Reset asserted mid-stall or mid-flush: the reset value is loaded on that edge; stall is ignored.
- No combinational path from any IF_* input to any ID_* output.

Optional Feature:
- Macro: IF_ID_PERF_COUNT_EN.
- Defined:
  - Adds outputs stall_cycles[31:0] and flush_count[31:0].
  - stall_cycles increments on each edge where stall=1 and no flush and no reset.
  - flush_count increments on each edge where handle_exception|eret_flush=1 and no reset.
  - Both counters wrap modulo 2^32. Both reset to 0 on reset only.
- Undefined: neither the ports nor the counters exist; all other behaviour is identical.

Test Plan:
- Reset: hold reset 2 cycles, then release. Required: ID_PC=0x3000, ID_Inst=0, ID_valid=0, delay_slot=0. Then IF_PC=0x3000, IF_Inst=0x3C010001. Required: next edge ID_PC=0x3000, ID_Inst=0x3C010001, ID_valid=1.
- Stall: stall=1 for 3 cycles while IF_PC changes 0x3004→0x3008. Required: ID_PC stays 0x3004 for all 3 cycles. Deassert stall. Required: ID_PC=0x3008 on the next edge. With the macro defined, stall_cycles=3.
- Faulting fetch: IF_exception=1, IF_EPC=0x3001_0000, IF_ExcCode=4, IF_Inst=0xFFFFFFFF. Required: ID_Inst=0, ID_exception=1, ID_EPC=0x3001_0000, ID_ExcCode=4, ID_valid=1.
- Flush vs stall: stall=1 and handle_exception=1 on the same edge. Required: bubble (ID_valid=0, ID_Inst=0); with the macro defined, flush_count=1 and stall_cycles unchanged.
- Delay slot: ID holds a beq at 0x3010 with ID_is_jump=1. Required: delay_slot=1, last_PC=0x3010. Flush, then keep ID_is_jump=1. Required: delay_slot=0.
- Mid-operation reset: reset=1 while stall=1 with ID_PC=0x3020. Required: next edge ID_PC=0x3000, ID_valid=0; with the macro defined, both counters are 0.
